// File: rtl/user_id_pkg.sv
// Shared definitions for the user project ID readback block:
// FSM encoding, register offsets and capture retry limits.
package user_id_pkg;

   typedef enum logic [2:0] {
      CAP_A  = 3'd0,
      SETTLE = 3'd1,
      CAP_B  = 3'd2,
      READY  = 3'd3,
      SHIFT  = 3'd4
   } state_t;

   localparam logic [2:0] OFF_ID     = 3'h0;
   localparam logic [2:0] OFF_STATUS = 3'h4;

   localparam logic [1:0] SETTLE_CYCLES = 2'd2;
   localparam logic [1:0] MAX_RETRY     = 2'd3;

endpackage

// File: rtl/user_id_serializer.sv
// Shifts a 32-bit ID out MSB first, each bit held CLK_DIV clocks,
// with a strobe on the last clock of every bit period.
module user_id_serializer #(
   parameter int CLK_DIV = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] id,
   output logic        ser_data,
   output logic        ser_strobe,
   output logic        ser_busy,
   output logic        done
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [31:0] shreg;
   logic [7:0]  div_cnt;
   logic [4:0]  bit_cnt;
   logic        busy;

   assign ser_strobe = busy && (div_cnt == DIV_LAST);
   assign done       = ser_strobe && (bit_cnt == 5'd31);
   assign ser_data   = shreg[31];
   assign ser_busy   = busy;

   // The shift register is cleared after the last bit so ser_data idles low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg   <= '0;
         div_cnt <= '0;
         bit_cnt <= '0;
         busy    <= 1'b0;
      end else if (!busy) begin
         if (start) begin
            busy    <= 1'b1;
            shreg   <= id;
            div_cnt <= '0;
            bit_cnt <= '0;
         end
      end else if (ser_strobe) begin
         div_cnt <= '0;
         if (bit_cnt == 5'd31) begin
            busy    <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
         end else begin
            bit_cnt <= bit_cnt + 5'd1;
            shreg   <= {shreg[30:0], 1'b0};
         end
      end else begin
         div_cnt <= div_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/user_id_readback.sv
// Captures the tie-cell project ID twice for consistency, exposes it over
// a two-word Wishbone window and can shift it out serially on request.
module user_id_readback
   import user_id_pkg::*;
#(
   parameter logic [31:0] BASE_ADR = 32'h2620_0000,
   parameter int          CLK_DIV  = 4
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [31:0] mask_rev,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [31:0] wbs_adr_i,
   output logic [31:0] wbs_dat_o,
   output logic        wbs_ack_o,
   input  logic        ser_start,
   output logic        ser_data,
   output logic        ser_strobe,
   output logic        ser_busy,
   output logic        id_valid,
   output logic        id_mismatch
);

   state_t      state, state_next;
   logic [31:0] id_a, id_b, shadow;
   logic [1:0]  retry;
   logic [1:0]  settle_cnt;
   logic        ser_done;
   logic        ser_go;
   logic        capture_match;
   logic        wb_hit;
   logic [31:0] rd_val;
   logic        unused_adr;

   assign unused_adr    = ^wbs_adr_i[1:0];
   assign capture_match = (id_a == mask_rev);
   assign ser_go        = (state == READY) && ser_start;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) state <= CAP_A;
      else          state <= state_next;
   end

   // A failed comparison only retries until the retry budget is spent.
   always_comb begin
      state_next = state;
      case (state)
         CAP_A:  state_next = SETTLE;
         SETTLE: if (settle_cnt == SETTLE_CYCLES - 2'd1) state_next = CAP_B;
         CAP_B:  state_next = (capture_match || retry == MAX_RETRY) ? READY : CAP_A;
         READY:  if (ser_start) state_next = SHIFT;
         SHIFT:  if (ser_done) state_next = READY;
         default: state_next = CAP_A;
      endcase
   end

   // id_b is registered in CAP_B, so the flags resolve one cycle later in READY.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         id_a        <= '0;
         id_b        <= '0;
         shadow      <= '0;
         retry       <= '0;
         settle_cnt  <= '0;
         id_valid    <= 1'b0;
         id_mismatch <= 1'b0;
      end else begin
         case (state)
            CAP_A: begin
               id_a       <= mask_rev;
               settle_cnt <= '0;
            end
            SETTLE: settle_cnt <= settle_cnt + 2'd1;
            CAP_B: begin
               id_b <= mask_rev;
               if (capture_match) begin
                  shadow <= id_a;
                  retry  <= '0;
               end else if (retry == MAX_RETRY) begin
                  shadow <= mask_rev;
               end else begin
                  retry <= retry + 2'd1;
               end
            end
            READY: begin
               id_valid    <= id_valid | (id_a == id_b);
               id_mismatch <= id_mismatch | (id_a != id_b);
            end
            default: ;
         endcase
      end
   end

   assign wb_hit = wbs_cyc_i && wbs_stb_i && !wbs_ack_o &&
                   (wbs_adr_i[31:3] == BASE_ADR[31:3]);

   always_comb begin
      rd_val = '0;
      if ({wbs_adr_i[2], 2'b00} == OFF_STATUS)
         rd_val = {30'b0, id_mismatch, id_valid};
      else if (id_valid || id_mismatch)
         rd_val = shadow;
   end

   // Read data is only driven alongside ack; writes return zero.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
      end else begin
         wbs_ack_o <= wb_hit;
         wbs_dat_o <= (wb_hit && !wbs_we_i) ? rd_val : '0;
      end
   end

   user_id_serializer #(
      .CLK_DIV(CLK_DIV)
   ) u_serializer (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .start     (ser_go),
      .id        (shadow),
      .ser_data  (ser_data),
      .ser_strobe(ser_strobe),
      .ser_busy  (ser_busy),
      .done      (ser_done)
   );

endmodule

// File: tb/tb_user_id_readback.sv
// Directed bench for user_id_readback: capture timing, Wishbone window,
// serial shift-out, start filtering, mid-shift reset and capture failure.
module tb_user_id_readback;

   logic        clk;
   logic        rst;
   logic [31:0] mask_rev;
   logic        cyc, stb, we;
   logic [31:0] adr;
   logic [31:0] wbs_dat_o;
   logic        wbs_ack_o;
   logic        ser_start;
   logic        ser_data, ser_strobe, ser_busy;
   logic        id_valid, id_mismatch;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] exp_rd[$];
   logic        exp_bits[$];

   user_id_readback dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .mask_rev   (mask_rev),
      .wbs_cyc_i  (cyc),
      .wbs_stb_i  (stb),
      .wbs_we_i   (we),
      .wbs_adr_i  (adr),
      .wbs_dat_o  (wbs_dat_o),
      .wbs_ack_o  (wbs_ack_o),
      .ser_start  (ser_start),
      .ser_data   (ser_data),
      .ser_strobe (ser_strobe),
      .ser_busy   (ser_busy),
      .id_valid   (id_valid),
      .id_mismatch(id_mismatch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One Wishbone access; strobe held over two edges so a second ack would show.
   task automatic applyStimulus(input logic [31:0] a, input logic wr, input logic exp_ack,
                                input logic [31:0] exp_dat, input string tag);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = wr; adr = a;
      if (exp_ack && !wr) exp_rd.push_back(exp_dat);
      @(posedge clk); #1;
      checkOutput({tag, " ack"}, 32'(wbs_ack_o), 32'(exp_ack));
      if (wbs_ack_o && !wr) begin
         if (exp_rd.size() == 0) checkOutput({tag, " unexpected ack"}, 32'd1, 32'd0);
         else                    checkOutput({tag, " data"}, wbs_dat_o, exp_rd.pop_front());
      end else begin
         checkOutput({tag, " data idle"}, wbs_dat_o, 32'h0);
      end
      exp_rd.delete();
      @(posedge clk); #1;
      checkOutput({tag, " no second ack"}, 32'(wbs_ack_o), 32'd0);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic waitCapture(input string tag);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (id_valid || id_mismatch) break;
      end
      checkOutput(tag, 32'(id_valid), 32'd1);
   endtask

   task automatic checkReleaseTiming(input string tag);
      repeat (4) @(posedge clk);
      #1 checkOutput({tag, " valid low at cycle 4"}, 32'(id_valid), 32'd0);
      @(posedge clk);
      #1 checkOutput({tag, " valid at cycle 5"}, 32'(id_valid), 32'd1);
   endtask

   initial begin
      int busy_cnt;
      int strobe_cnt;
      logic [31:0] ser_id;

      rst = 1'b1; mask_rev = 32'hA5C3_0F01;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; ser_start = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset dat", wbs_dat_o, 32'h0);
      checkOutput("reset flags", {26'b0, wbs_ack_o, ser_data, ser_strobe, ser_busy, id_valid, id_mismatch}, 32'h0);

      // Stable ID: capture timing and register window
      rst = 1'b0;
      checkReleaseTiming("stable");
      checkOutput("stable mismatch", 32'(id_mismatch), 32'd0);
      applyStimulus(32'h2620_0000, 1'b0, 1'b1, 32'hA5C3_0F01, "read id");
      applyStimulus(32'h2620_0004, 1'b0, 1'b1, 32'h0000_0001, "read status");
      applyStimulus(32'h2620_0008, 1'b0, 1'b0, 32'h0,         "read miss");
      applyStimulus(32'h2620_0000, 1'b1, 1'b1, 32'h0,         "write id");
      applyStimulus(32'h2620_0000, 1'b0, 1'b1, 32'hA5C3_0F01, "read after write");

      // Serial transfer; start during CAP_A and during SHIFT must be ignored
      ser_id = 32'h8000_0001;
      @(negedge clk); rst = 1'b1; mask_rev = ser_id;
      @(negedge clk); rst = 1'b0; ser_start = 1'b1;
      @(negedge clk); ser_start = 1'b0;
      checkOutput("start in CAP_A ignored", 32'(ser_busy), 32'd0);
      waitCapture("serial capture");
      @(negedge clk); ser_start = 1'b1;
      for (int i = 31; i >= 0; i--) exp_bits.push_back(ser_id[i]);
      busy_cnt = 0; strobe_cnt = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         ser_start = 1'b0; cyc = 1'b0; stb = 1'b0;
         if (ser_busy) busy_cnt++;
         if (wbs_ack_o) begin
            if (exp_rd.size() == 0) checkOutput("shift read unexpected ack", 32'd1, 32'd0);
            else                    checkOutput("read during shift", wbs_dat_o, exp_rd.pop_front());
         end
         if (ser_strobe) begin
            strobe_cnt++;
            if (exp_bits.size() == 0) checkOutput("extra strobe", 32'd1, 32'd0);
            else checkOutput($sformatf("serial bit %0d", 32 - strobe_cnt), 32'(ser_data), 32'(exp_bits.pop_front()));
         end
         if (k == 40) ser_start = 1'b1;
         if (k == 60) begin
            cyc = 1'b1; stb = 1'b1; adr = 32'h2620_0000;
            exp_rd.push_back(ser_id);
         end
      end
      checkOutput("busy cycles", busy_cnt, 32'd128);
      checkOutput("strobe count", strobe_cnt, 32'd32);
      checkOutput("bits left", exp_bits.size(), 32'd0);
      checkOutput("shift read pending", exp_rd.size(), 32'd0);
      checkOutput("idle ser_data", 32'(ser_data), 32'd0);
      exp_bits.delete(); exp_rd.delete();

      // Reset while presenting bit 10
      @(negedge clk); ser_start = 1'b1;
      @(negedge clk); ser_start = 1'b0;
      strobe_cnt = 0;
      for (int k = 0; k < 200 && strobe_cnt < 10; k++) begin
         @(negedge clk);
         if (ser_strobe) strobe_cnt++;
      end
      checkOutput("strobes before reset", strobe_cnt, 32'd10);
      @(posedge clk); #2;
      checkOutput("busy before reset", 32'(ser_busy), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("mid-shift reset flags", {26'b0, wbs_ack_o, ser_data, ser_strobe, ser_busy, id_valid, id_mismatch}, 32'h0);
      checkOutput("mid-shift reset dat", wbs_dat_o, 32'h0);
      @(negedge clk); rst = 1'b0;
      checkReleaseTiming("after abort");

      // Unstable ID: 4 mismatches then sticky failure
      @(negedge clk); rst = 1'b1; mask_rev = 32'h1;
      @(negedge clk); rst = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (k == 16) checkOutput("mismatch low at cycle 16", 32'(id_mismatch), 32'd0);
         if (k == 17) begin
            checkOutput("mismatch at cycle 17", 32'(id_mismatch), 32'd1);
            checkOutput("valid stays low", 32'(id_valid), 32'd0);
         end
         @(negedge clk);
         mask_rev = mask_rev ^ 32'h3;
      end
      applyStimulus(32'h2620_0004, 1'b0, 1'b1, 32'h0000_0002, "fail status");
      applyStimulus(32'h2620_0000, 1'b0, 1'b1, 32'h0000_0002, "fail shadow");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/user_id_readback.md
USER_ID_READBACK -- requirements
Module: user_id_readback

Interface
REQ-001 Parameter BASE_ADR, default 32'h2620_0000, Wishbone base address of the two-word register window.
REQ-002 Parameter CLK_DIV, default 4, legal 2..255, wb_clk_i cycles per serial bit.
REQ-003 wb_clk_i  in  1  the single clock; all state is on its rising edge.
REQ-004 wb_rst_i  in  1  asynchronous active-high reset.
REQ-005 mask_rev  in  32  project ID from the tie-cell ID programming block; static, not clock-related.
REQ-006 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone slave controls.
REQ-007 wbs_adr_i  in  32  Wishbone byte address.
REQ-008 wbs_dat_o  out  32  read data; wbs_ack_o  out  1  transfer acknowledge.
REQ-009 ser_start  in  1  single-cycle request to serialise the captured ID.
REQ-010 ser_data, ser_strobe, ser_busy  out  1 each  serial bit, bit-complete pulse, transfer in progress.
REQ-011 id_valid, id_mismatch  out  1 each  capture succeeded; capture failed after retries (sticky).

Function
REQ-012 FSM states SHALL be CAP_A, SETTLE, CAP_B, READY, SHIFT; reset enters CAP_A.
REQ-013 CAP_A SHALL register mask_rev into id_a, then spend exactly 2 cycles in SETTLE, then CAP_B SHALL register mask_rev into id_b.
REQ-014 On CAP_B: id_a==id_b -> id_valid=1, shadow ID=id_a, go READY; otherwise increment the 2-bit retry counter and return to CAP_A.
REQ-015 On the 4th consecutive mismatch, id_mismatch SHALL set (sticky until reset), shadow ID=id_b, id_valid stays 0, go READY.
REQ-016 First id_valid SHALL assert on cycle 5 after reset deassertion when inputs are stable (CAP_A, SETTLE x2, CAP_B, registered flag).
REQ-017 Wishbone hit = cyc&stb & adr[31:3]==BASE_ADR[31:3]; wbs_ack_o SHALL pulse one cycle, one cycle after the hit, and never on two consecutive cycles.
REQ-018 Read offset 0x0 SHALL return shadow ID, or 0 while neither id_valid nor id_mismatch is set; offset 0x4 SHALL return {30'b0, id_mismatch, id_valid}.
REQ-019 Writes SHALL be acknowledged identically and have no effect; wbs_dat_o SHALL be 0 when wbs_ack_o is 0.
REQ-020 ser_start in READY SHALL enter SHIFT next cycle; ser_start in any other state SHALL be ignored (not queued).
REQ-021 SHIFT SHALL present shadow ID MSB first, each bit held CLK_DIV cycles; ser_strobe SHALL pulse on the last cycle of each bit period.
REQ-022 ser_busy SHALL be 1 for exactly 32*CLK_DIV cycles in SHIFT; after bit 0's strobe, return to READY, ser_data=0.
REQ-023 Wishbone reads SHALL be serviced in every state, including during SHIFT, without disturbing it.

Reset
REQ-024 While wb_rst_i=1: all outputs 0, id_a/id_b/shadow/retry/bit and divider counters 0, state CAP_A.
REQ-025 Reset asserted mid-SHIFT or mid-Wishbone cycle SHALL abort immediately with no ack and restart capture on release.

Structure
REQ-026 Shared package user_id_pkg SHALL hold the FSM state encoding, register offsets (0x0, 0x4), SETTLE_CYCLES=2 and MAX_RETRY=3.
REQ-027 One sub-module, user_id_serializer (shift register + CLK_DIV divider + bit counter), SHALL implement REQ-021/022; the rest stays in the top.

Verification
REQ-028 mask_rev=32'hA5C3_0F01 stable, release reset -> id_valid=1 on cycle 5; read 0x2620_0000 -> 32'hA5C3_0F01, read 0x2620_0004 -> 32'h1.
REQ-029 mask_rev toggling between 32'h1 and 32'h2 every cycle -> after 4 mismatches id_mismatch=1, id_valid=0, status read -> 32'h2.
REQ-030 CLK_DIV=4, ID 32'h8000_0001, ser_start in READY -> ser_busy 128 cycles, 32 strobes, first bit 1, bits 30..1 0, last bit 1.
REQ-031 ser_start pulsed during SHIFT and during CAP_A -> ignored; exactly one 32-bit transfer observed.
REQ-032 Read 0x2620_0008 and write 0x2620_0000 -> no ack on miss; write acked, ID unchanged on readback.
REQ-033 Assert wb_rst_i at bit 10 of SHIFT -> outputs 0 immediately; on release capture restarts, id_valid after 5 cycles.
